// File: rtl/ysyx_041461_trap_ctrl_pkg.sv
// rtl/ysyx_041461_trap_ctrl_pkg.sv - shared CSR addresses, cause codes, mstatus fields and FSM encoding
package ysyx_041461_trap_ctrl_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_EBREAK   = 4'd3;
  localparam logic [3:0] CAUSE_ECALL    = 4'd11;
  // Low code bits of the machine interrupt cause; bit XLEN-1 is added in the top
  localparam logic [5:0] CAUSE_IRQ_CODE = 6'd7;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SAVE_EPC    = 3'd1,
    ST_SAVE_CAUSE  = 3'd2,
    ST_SAVE_STATUS = 3'd3,
    ST_MRET_STATUS = 3'd4,
    ST_REDIRECT    = 3'd5
  } state_e;

endpackage

// File: rtl/ysyx_041461_trap_ctrl.sv
// rtl/ysyx_041461_trap_ctrl.sv - M-mode trap/mret sequencer owning the CSR write port
module ysyx_041461_trap_ctrl
  import ysyx_041461_trap_ctrl_pkg::*;
#(
  parameter int XLEN        = 64,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req,
  input  logic [3:0]      exc_cause,
  input  logic [XLEN-1:0] exc_pc,
  input  logic            mret_req,
  input  logic            irq,
  input  logic [XLEN-1:0] irq_pc,
  output logic            exc_ack,
  output logic            mret_ack,
  input  logic [XLEN-1:0] csr_mtvec,
  input  logic [XLEN-1:0] csr_mepc,
  input  logic [XLEN-1:0] csr_mstatus,
  output logic            csr_wen,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  output logic            busy,
  output logic            flush,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc
);

  localparam logic [XLEN-1:0] IRQ_CAUSE = {1'b1, {(XLEN-7){1'b0}}, CAUSE_IRQ_CODE};
  localparam logic [XLEN-1:0] EPC_MASK  = ~{{(XLEN-1){1'b0}}, 1'b1};

  state_e          state_q, state_d;
  logic [XLEN-1:0] epc_q, epc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic            is_irq_q, is_irq_d;
  logic            mret_q, mret_d;

  function automatic logic [XLEN-1:0] trap_status(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MPIE] = ms[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  function automatic logic [XLEN-1:0] mret_status(input logic [XLEN-1:0] ms);
    logic [XLEN-1:0] r;
    r = ms;
    r[MSTATUS_MIE]  = ms[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // Vectoring applies to interrupts only; exceptions always land on the base
  function automatic logic [XLEN-1:0] trap_target(input logic [XLEN-1:0] mtvec,
                                                  input logic [5:0]      code,
                                                  input logic            from_irq);
    logic [XLEN-1:0] base;
    base = {mtvec[XLEN-1:2], 2'b00};
    if (VECTORED_EN && from_irq && (mtvec[1:0] == 2'b01))
      return base + {{(XLEN-8){1'b0}}, code, 2'b00};
    return base;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      epc_q    <= '0;
      cause_q  <= '0;
      is_irq_q <= 1'b0;
      mret_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      epc_q    <= epc_d;
      cause_q  <= cause_d;
      is_irq_q <= is_irq_d;
      mret_q   <= mret_d;
    end
  end

  // Every output is forced low while reset is asserted, including the IDLE accept strobes
  always_comb begin
    state_d        = state_q;
    epc_d          = epc_q;
    cause_d        = cause_q;
    is_irq_d       = is_irq_q;
    mret_d         = mret_q;
    exc_ack        = 1'b0;
    mret_ack       = 1'b0;
    flush          = 1'b0;
    busy           = 1'b0;
    csr_wen        = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    if (rst) begin
      unique case (state_q)
        ST_IDLE: begin
          if (exc_req) begin
            exc_ack  = 1'b1;
            flush    = 1'b1;
            epc_d    = exc_pc;
            cause_d  = {{(XLEN-4){1'b0}}, exc_cause};
            is_irq_d = 1'b0;
            mret_d   = 1'b0;
            state_d  = ST_SAVE_EPC;
          end else if (mret_req) begin
            mret_ack = 1'b1;
            flush    = 1'b1;
            is_irq_d = 1'b0;
            mret_d   = 1'b1;
            state_d  = ST_MRET_STATUS;
          end else if (irq && csr_mstatus[MSTATUS_MIE]) begin
            flush    = 1'b1;
            epc_d    = irq_pc;
            cause_d  = IRQ_CAUSE;
            is_irq_d = 1'b1;
            mret_d   = 1'b0;
            state_d  = ST_SAVE_EPC;
          end
        end
        ST_SAVE_EPC: begin
          busy      = 1'b1;
          csr_wen   = 1'b1;
          csr_waddr = CSR_MEPC;
          csr_wdata = epc_q & EPC_MASK;
          state_d   = ST_SAVE_CAUSE;
        end
        ST_SAVE_CAUSE: begin
          busy      = 1'b1;
          csr_wen   = 1'b1;
          csr_waddr = CSR_MCAUSE;
          csr_wdata = cause_q;
          state_d   = ST_SAVE_STATUS;
        end
        ST_SAVE_STATUS: begin
          busy      = 1'b1;
          csr_wen   = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = trap_status(csr_mstatus);
          state_d   = ST_REDIRECT;
        end
        ST_MRET_STATUS: begin
          busy      = 1'b1;
          csr_wen   = 1'b1;
          csr_waddr = CSR_MSTATUS;
          csr_wdata = mret_status(csr_mstatus);
          state_d   = ST_REDIRECT;
        end
        ST_REDIRECT: begin
          busy           = 1'b1;
          redirect_valid = 1'b1;
          redirect_pc    = mret_q ? csr_mepc : trap_target(csr_mtvec, cause_q[5:0], is_irq_q);
          state_d        = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_041461_trap_ctrl.sv
// tb/tb_ysyx_041461_trap_ctrl.sv - vector table, random model check and corner sequences for trap_ctrl
module tb_ysyx_041461_trap_ctrl;
  import ysyx_041461_trap_ctrl_pkg::*;

  localparam int K_EXC  = 0;
  localparam int K_MRET = 1;
  localparam int K_IRQ  = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        exc_req, mret_req, irq;
  logic [3:0]  exc_cause;
  logic [63:0] exc_pc, irq_pc, csr_mtvec, csr_mepc, csr_mstatus;
  logic        exc_ack, mret_ack, csr_wen, busy, flush, redirect_valid;
  logic [11:0] csr_waddr;
  logic [63:0] csr_wdata, redirect_pc;

  always #5 clk = ~clk;

  ysyx_041461_trap_ctrl #(.XLEN(64), .VECTORED_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .exc_req(exc_req), .exc_cause(exc_cause), .exc_pc(exc_pc),
    .mret_req(mret_req), .irq(irq), .irq_pc(irq_pc),
    .exc_ack(exc_ack), .mret_ack(mret_ack),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc), .csr_mstatus(csr_mstatus),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .busy(busy), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  typedef struct {
    int          kind;
    logic [3:0]  cause;
    logic [63:0] pc, mtvec, mepc, mstatus;
    logic [63:0] e_w0, e_w1, e_w2, e_tgt;
  } vec_t;

  typedef struct {
    logic        wen;
    logic [11:0] addr;
    logic [63:0] data;
    logic        rv;
    logic [63:0] rpc;
  } out_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural rules written as plain arithmetic on the CSR values
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [63:0] ms, base;
    r  = v;
    ms = v.mstatus;
    if (v.kind == K_MRET) begin
      r.e_w0  = (ms & ~64'h1888) | 64'h1880 | (((ms >> 7) & 64'd1) << 3);
      r.e_w1  = 64'd0;
      r.e_w2  = 64'd0;
      r.e_tgt = v.mepc;
    end else begin
      r.e_w0  = v.pc - (v.pc % 2);
      r.e_w1  = (v.kind == K_IRQ) ? (64'd1 << 63) + 64'd7 : 64'(v.cause);
      r.e_w2  = (ms & ~64'h1888) | 64'h1800 | (((ms >> 3) & 64'd1) << 7);
      base    = v.mtvec - (v.mtvec % 4);
      r.e_tgt = (v.kind == K_IRQ && v.mtvec % 4 == 1) ? base + 64'd4 * 64'd7 : base;
    end
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, busy, 0);
    check({tag, ".csr_wen"}, csr_wen, 0);
    check({tag, ".redirect_valid"}, redirect_valid, 0);
    check({tag, ".exc_ack"}, exc_ack, 0);
    check({tag, ".mret_ack"}, mret_ack, 0);
    check({tag, ".flush"}, flush, 0);
  endtask

  // Walks the post-accept cycles, playing the CSR file by committing each expected write
  task automatic follow(input vec_t v);
    out_t q[$];
    if (v.kind == K_MRET) begin
      q.push_back('{1'b1, CSR_MSTATUS, v.e_w0, 1'b0, 64'd0});
    end else begin
      q.push_back('{1'b1, CSR_MEPC,    v.e_w0, 1'b0, 64'd0});
      q.push_back('{1'b1, CSR_MCAUSE,  v.e_w1, 1'b0, 64'd0});
      q.push_back('{1'b1, CSR_MSTATUS, v.e_w2, 1'b0, 64'd0});
    end
    q.push_back('{1'b0, 12'd0, 64'd0, 1'b1, v.e_tgt});
    foreach (q[i]) begin
      @(negedge clk);
      check("seq.busy", busy, 1);
      check("seq.flush", flush, 0);
      check("seq.acks", {exc_ack, mret_ack}, 0);
      check("seq.csr_wen", csr_wen, q[i].wen);
      check("seq.csr_waddr", csr_waddr, q[i].addr);
      check("seq.csr_wdata", csr_wdata, q[i].data);
      check("seq.redirect_valid", redirect_valid, q[i].rv);
      check("seq.redirect_pc", redirect_pc, q[i].rpc);
      if (q[i].wen && q[i].addr == CSR_MSTATUS) csr_mstatus = q[i].data;
      if (q[i].wen && q[i].addr == CSR_MEPC)    csr_mepc    = q[i].data;
    end
  endtask

  task automatic drive(input vec_t v);
    csr_mtvec   = v.mtvec;
    csr_mepc    = v.mepc;
    csr_mstatus = v.mstatus;
    exc_cause   = v.cause;
    exc_pc      = (v.kind == K_IRQ) ? ~v.pc : v.pc;
    irq_pc      = (v.kind == K_IRQ) ? v.pc : ~v.pc;
    exc_req     = (v.kind == K_EXC);
    mret_req    = (v.kind == K_MRET);
    irq         = (v.kind == K_IRQ);
  endtask

  task automatic run_vec(input vec_t v);
    drive(v);
    #1;
    check("acc.exc_ack", exc_ack, (v.kind == K_EXC));
    check("acc.mret_ack", mret_ack, (v.kind == K_MRET));
    check("acc.flush", flush, 1);
    check("acc.busy", busy, 0);
    @(posedge clk);
    #1;
    exc_req  = 1'b0;
    mret_req = 1'b0;
    irq      = 1'b0;
    follow(v);
    @(negedge clk);
    check_quiet("idle");
  endtask

  vec_t tbl[8];
  vec_t v, v2;

  initial begin
    tbl[0] = '{K_EXC,  4'd11, 64'h8000_0010, 64'h8000_1000, 64'h0, 64'h8,
               64'h8000_0010, 64'd11, 64'h1880, 64'h8000_1000};
    tbl[1] = '{K_MRET, 4'd0, 64'h0, 64'h8000_1000, 64'h8000_0014, 64'h1880,
               64'h1888, 64'h0, 64'h0, 64'h8000_0014};
    tbl[2] = '{K_IRQ,  4'd0, 64'h8000_0200, 64'h8000_1001, 64'h0, 64'h8,
               64'h8000_0200, 64'h8000_0000_0000_0007, 64'h1880, 64'h8000_101C};
    tbl[3] = '{K_EXC,  4'd2, 64'h8000_0023, 64'h8000_2001, 64'h0, 64'h0,
               64'h8000_0022, 64'd2, 64'h1800, 64'h8000_2000};
    tbl[4] = '{K_MRET, 4'd0, 64'h0, 64'h0, 64'h0, 64'h0,
               64'h1880, 64'h0, 64'h0, 64'h0};
    tbl[5] = '{K_EXC,  4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0,
               64'hFFFF_FFFF_FFFF_FFFF,
               64'hFFFF_FFFF_FFFF_FFFE, 64'd3, 64'hFFFF_FFFF_FFFF_FFF7, 64'hFFFF_FFFF_FFFF_FFFC};
    tbl[6] = '{K_IRQ,  4'd0, 64'h1234, 64'hFFFF_FFFF_FFFF_FFF1, 64'h0, 64'h88,
               64'h1234, 64'h8000_0000_0000_0007, 64'h1880, 64'h0000_0000_0000_000C};
    tbl[7] = '{K_MRET, 4'd0, 64'h0, 64'h0, 64'h400, 64'h8,
               64'h1880, 64'h0, 64'h0, 64'h400};

    // Reset: requests present but every output must stay low
    rst = 1'b0; exc_req = 1'b1; mret_req = 1'b0; irq = 1'b1; exc_cause = 4'd11;
    exc_pc = 64'h100; irq_pc = 64'h200;
    csr_mtvec = 64'h8000_1000; csr_mepc = 64'h0; csr_mstatus = 64'h8;
    repeat (2) @(negedge clk);
    check_quiet("reset");
    check("reset.csr_waddr", csr_waddr, 0);
    check("reset.csr_wdata", csr_wdata, 0);
    check("reset.redirect_pc", redirect_pc, 0);
    exc_req = 1'b0; irq = 1'b0; rst = 1'b1;
    @(negedge clk);
    check_quiet("post_reset");

    foreach (tbl[i]) run_vec(tbl[i]);

    for (int i = 0; i < 40; i++) begin
      v.kind    = int'($urandom_range(0, 2));
      case ($urandom_range(0, 2))
        0:       v.cause = CAUSE_ILLEGAL;
        1:       v.cause = CAUSE_EBREAK;
        default: v.cause = CAUSE_ECALL;
      endcase
      v.pc      = {$urandom, $urandom};
      v.mtvec   = {$urandom, $urandom};
      v.mepc    = {$urandom, $urandom};
      v.mstatus = {$urandom, $urandom};
      if ($urandom_range(0, 1) == 1) v.mtvec[1:0] = 2'b01;
      if (v.kind == K_IRQ) v.mstatus[MSTATUS_MIE] = 1'b1;
      run_vec(model(v));
    end

    // All three events at once with MIE clear: exception, then mret, then irq stays blocked
    v = '{K_EXC, CAUSE_ECALL, 64'h8000_0600, 64'h8000_4000, 64'h8000_0500, 64'h0,
          64'h0, 64'h0, 64'h0, 64'h0};
    v = model(v);
    drive(v);
    mret_req = 1'b1;
    irq      = 1'b1;
    irq_pc   = 64'h8000_0700;
    #1;
    check("both.exc_ack", exc_ack, 1);
    check("both.mret_ack", mret_ack, 0);
    @(posedge clk);
    #1;
    exc_req = 1'b0;
    follow(v);
    @(negedge clk);
    check("both.mret_ack_idle", mret_ack, 1);
    check("both.exc_ack_idle", exc_ack, 0);
    check("both.flush_idle", flush, 1);
    v2 = '{K_MRET, 4'd0, 64'h0, csr_mtvec, csr_mepc, csr_mstatus, 64'h0, 64'h0, 64'h0, 64'h0};
    v2 = model(v2);
    check("both.mret_target", v2.e_tgt, 64'h8000_0600);
    @(posedge clk);
    #1;
    mret_req = 1'b0;
    follow(v2);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check_quiet("irq_masked");
    end
    irq = 1'b0;

    // Reset asserted during SAVE_CAUSE with exc_req still held
    v = '{K_EXC, CAUSE_ILLEGAL, 64'h8000_0100, 64'h8000_3000, 64'h0, 64'h8,
          64'h0, 64'h0, 64'h0, 64'h0};
    v = model(v);
    drive(v);
    #1;
    check("rst_mid.accept", exc_ack, 1);
    @(negedge clk);
    check("rst_mid.epc_addr", csr_waddr, CSR_MEPC);
    csr_mepc = v.e_w0;
    @(negedge clk);
    check("rst_mid.cause_addr", csr_waddr, CSR_MCAUSE);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("rst_mid.idle");
    check("rst_mid.csr_waddr", csr_waddr, 0);
    rst = 1'b1;
    #1;
    check("rst_mid.reaccept", exc_ack, 1);
    check("rst_mid.reflush", flush, 1);
    @(posedge clk);
    #1;
    exc_req = 1'b0;
    follow(v);
    @(negedge clk);
    check_quiet("rst_mid.done");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
